// File: rtl/fa_serial_sub.sv
// Bit-serial subtractor d = a - b - bi: one full-adder cell plus a carry flop, LSB first.
// Optional `FA_SERIAL_ADD_EN adds a `sub` port selecting add (0) or subtract (1).
module fa_serial_sub #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bi,
`ifdef FA_SERIAL_ADD_EN
    input  logic             sub,
`endif
    output logic [WIDTH-1:0] d,
    output logic             bo,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] ra, rb, rr;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             b_bit, sum, cout, last;
`ifdef FA_SERIAL_ADD_EN
    logic             rsub;
`endif

    // Subtraction is a + ~b + 1 - bi, so the second operand bit is inverted
    // and the carry chain starts from ~bi.
    always_comb begin
`ifdef FA_SERIAL_ADD_EN
        b_bit = rsub ? ~rb[0] : rb[0];
`else
        b_bit = ~rb[0];
`endif
        sum  = ra[0] ^ b_bit ^ carry;
        cout = (ra[0] & b_bit) | (ra[0] & carry) | (b_bit & carry);
        last = (cnt == CW'(WIDTH - 1));
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (last)  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ra    <= '0;
            rb    <= '0;
            rr    <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            d     <= '0;
            bo    <= 1'b0;
`ifdef FA_SERIAL_ADD_EN
            rsub  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        ra  <= a;
                        rb  <= b;
                        cnt <= '0;
`ifdef FA_SERIAL_ADD_EN
                        rsub  <= sub;
                        carry <= sub ? ~bi : bi;
`else
                        carry <= ~bi;
`endif
                    end
                end
                SHIFT: begin
                    carry <= cout;
                    ra    <= ra >> 1;
                    rb    <= rb >> 1;
                    rr    <= {sum, rr[WIDTH-1:1]};
                    cnt   <= cnt + CW'(1);
                    if (last) begin
                        d <= {sum, rr[WIDTH-1:1]};
`ifdef FA_SERIAL_ADD_EN
                        bo <= rsub ? ~cout : cout;
`else
                        bo <= ~cout;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

endmodule

// File: tb/tb_fa_serial_sub.sv
// Directed and exhaustive self-checking bench for fa_serial_sub (WIDTH=4).
// Define FA_SERIAL_ADD_EN to also exercise the add mode.
module tb_fa_serial_sub;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         bi = 1'b0;
    logic         sub = 1'b1;
    logic [W-1:0] d;
    logic         bo, busy, done;

    int n_vec = 0;
    int n_mis = 0;

    fa_serial_sub #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bi    (bi),
`ifdef FA_SERIAL_ADD_EN
        .sub   (sub),
`endif
        .d     (d),
        .bo    (bo),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: subtract gives borrow (a < b+bi); add gives carry out.
    function automatic logic [W:0] model(input int ta, input int tb_, input int tbi, input int ts);
        int         r;
        logic [W:0] res;
        r = ts != 0 ? ta - tb_ - tbi : ta + tb_ + tbi;
        res[W-1:0] = r[W-1:0];
        res[W]     = ts != 0 ? (ta < tb_ + tbi) : (r > 15);
        return res;
    endfunction

    // Pulses start for one cycle, waits for done, checks latency, busy span, result and pulse width.
    task automatic run_op(input string tag, input int ta, input int tb_, input int tbi, input int ts,
                          input int exp_d, input int exp_bo);
        int cycles;
        int busy_cnt;
        cycles   = 0;
        busy_cnt = 0;
        @(negedge clk);
        a = W'(ta); b = W'(tb_); bi = tbi[0]; sub = ts[0];
        start = 1'b1;
        while (cycles < 20) begin
            @(negedge clk);
            start = 1'b0;
            cycles++;
            if (busy) busy_cnt++;
            if (done) break;
        end
        if (!done) check({tag, "_timeout"}, done, 1);
        check({tag, "_latency"}, cycles, W + 1);
        check({tag, "_busy"}, busy_cnt, W);
        check({tag, "_d"}, d, exp_d);
        check({tag, "_bo"}, bo, exp_bo);
        @(negedge clk);
        check({tag, "_pulse"}, done, 0);
    endtask

    initial begin
        int         cycles;
        int         nbusy;
        int         nsub;
        logic [W:0] exp;

        // Reset state
        #2;
        check("rst_d", d, 0);
        check("rst_bo", bo, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors from hand computation
        run_op("v9m3", 9, 3, 0, 1, 6, 0);
        run_op("v3m9", 3, 9, 0, 1, 10, 1);
        run_op("v0m0b", 0, 0, 1, 1, 15, 1);
        run_op("v15m15", 15, 15, 0, 1, 0, 0);
        run_op("v8m7b", 8, 7, 1, 1, 0, 0);

        // Start pulses during SHIFT and DONE plus operand changes must be ignored
        @(negedge clk);
        a = 4'd9; b = 4'd3; bi = 1'b0; sub = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 4'd3; b = 4'd9; bi = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cycles = 0;
        while (!done && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        check("ign_done", done, 1);
        check("ign_d", d, 6);
        check("ign_bo", bo, 0);
        a = 4'd0; b = 4'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("ign_idle_busy", busy, 0);
        repeat (3) @(negedge clk);
        check("ign_later_busy", busy, 0);
        check("ign_later_done", done, 0);
        check("ign_hold_d", d, 6);

        // Reset during the third SHIFT cycle aborts without a done pulse
        a = 4'd3; b = 4'd9; bi = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nbusy = busy ? 1 : 0;
        cycles = 0;
        while (nbusy < 3 && cycles < 20) begin
            @(negedge clk);
            cycles++;
            if (busy) nbusy++;
        end
        check("abort_reached", nbusy, 3);
        rst_n = 1'b0;
        #1;
        check("abort_d", d, 0);
        check("abort_bo", bo, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        @(negedge clk);
        @(negedge clk);
        check("abort_no_done", done, 0);
        rst_n = 1'b1;
        run_op("after_rst", 3, 9, 0, 1, 10, 1);

`ifdef FA_SERIAL_ADD_EN
        run_op("add_9p8b", 9, 8, 1, 0, 2, 1);
        run_op("add_3p4", 3, 4, 0, 0, 7, 0);
        nsub = 2;
`else
        nsub = 1;
`endif

        // Exhaustive sweep with start held high: back-to-back every W+2 cycles
        for (int s = 0; s < nsub; s++) begin
            @(negedge clk);
            sub = (s == 0);
            a = 4'd0; b = 4'd0; bi = 1'b0;
            start = 1'b1;
            for (int idx = 0; idx < 512; idx++) begin
                int ta, tb_, tbi;
                ta  = idx % 16;
                tb_ = (idx / 16) % 16;
                tbi = idx / 256;
                cycles = 0;
                while (cycles < 20) begin
                    @(negedge clk);
                    cycles++;
                    if (done) break;
                end
                if (!done) check($sformatf("sweep_timeout_%0d", idx), done, 1);
                check($sformatf("sweep_cyc_s%0d_%0d", s, idx), cycles, idx == 0 ? W + 1 : W + 2);
                exp = model(ta, tb_, tbi, (s == 0) ? 1 : 0);
                check($sformatf("sweep_d_s%0d_a%0d_b%0d_bi%0d", s, ta, tb_, tbi), d, exp[W-1:0]);
                check($sformatf("sweep_bo_s%0d_a%0d_b%0d_bi%0d", s, ta, tb_, tbi), bo, exp[W]);
                if (idx < 511) begin
                    a  = W'((idx + 1) % 16);
                    b  = W'(((idx + 1) / 16) % 16);
                    bi = ((idx + 1) / 256) != 0;
                end
            end
            start = 1'b0;
            repeat (3) @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
